// File: rtl/bidir_rx_deser.sv
`default_nettype none
// bidir_rx_deser: oversampled UART-style deserialiser on the bidir RX line, one byte per AXI-stream beat.
// Optional even-parity bit: define BIDIR_RX_PARITY_EN. Rev 1.0
module bidir_rx_deser #(
   parameter int DW       = 8,
   parameter int OSR      = 16,
   parameter int GAP_BITS = 12,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_en,
   input  logic          rx_in,
   output logic [DW-1:0] m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          m_axis_tlast,
   output logic          m_axis_tuser,
   output logic          overrun_o,
   input  logic          clr_err_i,
   output logic          busy_o
);
   localparam int              BW        = $clog2(DW + 1);
   localparam logic [CW-1:0]   HALF_TICK = CW'(OSR / 2 - 1);
   localparam logic [CW-1:0]   LAST_TICK = CW'(OSR - 1);
   localparam logic [CW-1:0]   GAP_LIMIT = CW'(OSR * GAP_BITS);
   localparam logic [BW-1:0]   LAST_BIT  = BW'(DW - 1);

`ifdef BIDIR_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

   state_t          state, state_nxt;
   logic            rx_m, rx_s, rx_d;
   logic            fall, mid_bit;
   logic            tick_clr, start_now, bit_done, stop_done;
   logic [CW-1:0]   tick;
   logic [BW-1:0]   bit_cnt;
   logic [DW-1:0]   shreg;
   logic            p_valid, p_err;
   logic [DW-1:0]   p_data;
   logic [CW-1:0]   gap;
   logic            gap_hit, out_free, promote, p_busy, load, byte_err;
`ifdef BIDIR_RX_PARITY_EN
   logic            par_done, par_err;
`endif

   // rx_d holds the previous synchronised sample for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall    = rx_d & ~rx_s;
   assign mid_bit = (tick == LAST_TICK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tick_clr  = 1'b0;
      start_now = 1'b0;
      bit_done  = 1'b0;
      stop_done = 1'b0;
`ifdef BIDIR_RX_PARITY_EN
      par_done  = 1'b0;
`endif
      case (state)
         IDLE: if (rx_en && fall) begin
            state_nxt = START;
            tick_clr  = 1'b1;
            start_now = 1'b1;
         end
         START: if (tick == HALF_TICK) begin
            tick_clr  = 1'b1;
            state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: if (mid_bit) begin
            tick_clr = 1'b1;
            bit_done = 1'b1;
`ifdef BIDIR_RX_PARITY_EN
            if (bit_cnt == LAST_BIT) state_nxt = PAR;
`else
            if (bit_cnt == LAST_BIT) state_nxt = STOP;
`endif
         end
`ifdef BIDIR_RX_PARITY_EN
         PAR: if (mid_bit) begin
            tick_clr  = 1'b1;
            par_done  = 1'b1;
            state_nxt = STOP;
         end
`endif
         STOP: if (mid_bit) begin
            tick_clr  = 1'b1;
            stop_done = 1'b1;
            state_nxt = rx_s ? IDLE : WAIT_HI;
         end
         WAIT_HI: if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Disabling abandons any frame in flight without touching pending/output
      if (!rx_en) begin
         state_nxt = IDLE;
         start_now = 1'b0;
         bit_done  = 1'b0;
         stop_done = 1'b0;
`ifdef BIDIR_RX_PARITY_EN
         par_done  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
`ifdef BIDIR_RX_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         if (tick_clr || state == IDLE) tick <= '0;
         else                           tick <= tick + CW'(1);
         if (state == START)    bit_cnt <= '0;
         else if (bit_done)     bit_cnt <= bit_cnt + BW'(1);
         if (bit_done)          shreg   <= {rx_s, shreg[DW-1:1]};
`ifdef BIDIR_RX_PARITY_EN
         if (state == START)    par_err <= 1'b0;
         else if (par_done)     par_err <= rx_s ^ (^shreg);
`endif
      end
   end

`ifdef BIDIR_RX_PARITY_EN
   assign byte_err = ~rx_s | par_err;
`else
   assign byte_err = ~rx_s;
`endif

   // A saturated gap counter keeps the tlast=1 decision alive while pending is blocked
   assign gap_hit  = (gap == GAP_LIMIT);
   assign out_free = ~m_axis_tvalid | m_axis_tready;
   assign promote  = p_valid & (gap_hit | start_now) & out_free;
   assign p_busy   = p_valid & ~promote;
   assign load     = stop_done & ~p_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_valid       <= 1'b0;
         p_data        <= '0;
         p_err         <= 1'b0;
         gap           <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         overrun_o     <= 1'b0;
      end else begin
         if (load) begin
            p_valid <= 1'b1;
            p_data  <= shreg;
            p_err   <= byte_err;
         end else if (promote) begin
            p_valid <= 1'b0;
         end

         if (load)
            gap <= '0;
         else if (p_valid && state == IDLE && !gap_hit)
            gap <= gap + CW'(1);

         if (promote) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= p_data;
            m_axis_tlast  <= gap_hit;
            m_axis_tuser  <= p_err;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         if (stop_done && p_busy) overrun_o <= 1'b1;
         else if (clr_err_i)      overrun_o <= 1'b0;
      end
   end

   assign busy_o = (state != IDLE) | p_valid;

endmodule
`default_nettype wire

// File: tb/tb_bidir_rx_deser.sv
`default_nettype none
// tb_bidir_rx_deser: directed self-checking bench for bidir_rx_deser (OSR=16, GAP_BITS=12, DW=8).
module tb_bidir_rx_deser;
   localparam int OSR = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_en = 1'b0;
   logic       rx_in = 1'b1;
   logic       m_axis_tready = 1'b0;
   logic       clr_err_i = 1'b0;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser, overrun_o, busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] q_data[$];
   logic       q_last[$];
   logic       q_user[$];

   always #5 clk = ~clk;

   bidir_rx_deser dut (
      .clk           (clk),
      .rst           (rst),
      .rx_en         (rx_en),
      .rx_in         (rx_in),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .overrun_o     (overrun_o),
      .clr_err_i     (clr_err_i),
      .busy_o        (busy_o)
   );

   // Record every accepted beat
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         q_data.push_back(m_axis_tdata);
         q_last.push_back(m_axis_tlast);
         q_user.push_back(m_axis_tuser);
      end
   end

   function automatic logic [9:0] beat(input int i);
      if (i < q_data.size()) return {q_data[i], q_last[i], q_user[i]};
      return 10'bx;
   endfunction

   task automatic clear_q();
      q_data.delete();
      q_last.delete();
      q_user.delete();
   endtask

   task automatic drive_bit(input logic b);
      rx_in = b;
      repeat (OSR) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef BIDIR_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(stop_v);
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, overrun_o, busy_o} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b expected 00000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, overrun_o, busy_o});
      end
      n_cmp++;
      if (m_axis_tdata !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata);
      end
      rst = 1'b0;
      rx_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if ({m_axis_tvalid, busy_o, overrun_o} !== 3'b000) begin
         n_bad++;
         $display("FAIL post_reset_idle: got %b expected 000", {m_axis_tvalid, busy_o, overrun_o});
      end
   endtask

   task automatic test_back_to_back();
      m_axis_tready = 1'b1;
      clear_q();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3C, 1'b1);
      repeat (180) @(posedge clk);
      #1;
      n_cmp++;
      if (q_data.size() !== 1) begin
         n_bad++;
         $display("FAIL b2b_early_count: got %0d beats expected 1", q_data.size());
      end
      n_cmp++;
      if (beat(0) !== {8'hA5, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL b2b_beat0: got %h expected %h", beat(0), {8'hA5, 1'b0, 1'b0});
      end
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if (beat(1) !== {8'h3C, 1'b1, 1'b0} || q_data.size() !== 2) begin
         n_bad++;
         $display("FAIL b2b_beat1: got %h (%0d beats) expected %h", beat(1), q_data.size(), {8'h3C, 1'b1, 1'b0});
      end
   endtask

   task automatic test_glitch();
      clear_q();
      rx_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL glitch_busy_start: got %b expected 1", busy_o);
      end
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy_o, m_axis_tvalid} !== 2'b00 || q_data.size() !== 0) begin
         n_bad++;
         $display("FAIL glitch_idle: got busy=%b tvalid=%b beats=%0d expected 0 0 0", busy_o, m_axis_tvalid, q_data.size());
      end
   endtask

   task automatic test_framing();
      clear_q();
      send_byte(8'h55, 1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      send_byte(8'h12, 1'b1);
      repeat (210) @(posedge clk);
      #1;
      n_cmp++;
      if (q_data.size() !== 2) begin
         n_bad++;
         $display("FAIL framing_count: got %0d beats expected 2", q_data.size());
      end
      n_cmp++;
      if (beat(0) !== {8'h55, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL framing_err_beat: got %h expected %h", beat(0), {8'h55, 1'b0, 1'b1});
      end
      n_cmp++;
      if (beat(1) !== {8'h12, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL framing_clean_beat: got %h expected %h", beat(1), {8'h12, 1'b1, 1'b0});
      end
   endtask

   task automatic test_overrun();
      m_axis_tready = 1'b0;
      clear_q();
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      repeat (210) @(posedge clk);
      #1;
      n_cmp++;
      if (overrun_o !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_set: got %b expected 1", overrun_o);
      end
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, 8'h01, 1'b0}) begin
         n_bad++;
         $display("FAIL overrun_held_beat: got %h expected %h", {m_axis_tvalid, m_axis_tdata, m_axis_tlast}, {1'b1, 8'h01, 1'b0});
      end
      m_axis_tready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (q_data.size() !== 2) begin
         n_bad++;
         $display("FAIL overrun_count: got %0d beats expected 2", q_data.size());
      end
      n_cmp++;
      if (beat(0) !== {8'h01, 1'b0, 1'b0} || beat(1) !== {8'h02, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL overrun_beats: got %h %h expected %h %h", beat(0), beat(1), {8'h01, 1'b0, 1'b0}, {8'h02, 1'b1, 1'b0});
      end
      clr_err_i = 1'b1;
      @(posedge clk);
      #1;
      clr_err_i = 1'b0;
      n_cmp++;
      if (overrun_o !== 1'b0) begin
         n_bad++;
         $display("FAIL overrun_clear: got %b expected 0", overrun_o);
      end
   endtask

   task automatic test_rst_mid_frame();
      logic [7:0] f0;
      f0 = 8'hF0;
      m_axis_tready = 1'b0;
      clear_q();
      send_byte(8'h11, 1'b1);
      repeat (210) @(posedge clk);
      #1;
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'h11}) begin
         n_bad++;
         $display("FAIL rst_waiting_beat: got %h expected %h", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h11});
      end
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(f0[i]);
      rx_in = f0[4];
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, overrun_o, busy_o, m_axis_tdata} !== 13'b0) begin
         n_bad++;
         $display("FAIL rst_async_clear: got %h expected 0000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, overrun_o, busy_o, m_axis_tdata});
      end
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      m_axis_tready = 1'b1;
      clear_q();
      repeat (4) @(posedge clk);
      #1;
      send_byte(8'h7E, 1'b1);
      repeat (210) @(posedge clk);
      #1;
      n_cmp++;
      if (beat(0) !== {8'h7E, 1'b1, 1'b0} || q_data.size() !== 1) begin
         n_bad++;
         $display("FAIL rst_next_frame: got %h (%0d beats) expected %h", beat(0), q_data.size(), {8'h7E, 1'b1, 1'b0});
      end
   endtask

`ifdef BIDIR_RX_PARITY_EN
   task automatic send_par_frame(input logic [7:0] d, input logic par_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par_v);
      drive_bit(1'b1);
   endtask

   task automatic test_parity();
      m_axis_tready = 1'b1;
      clear_q();
      send_par_frame(8'h03, 1'b1);
      send_par_frame(8'h03, 1'b0);
      repeat (220) @(posedge clk);
      #1;
      n_cmp++;
      if (beat(0) !== {8'h03, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL parity_bad: got %h expected %h", beat(0), {8'h03, 1'b0, 1'b1});
      end
      n_cmp++;
      if (beat(1) !== {8'h03, 1'b1, 1'b0} || q_data.size() !== 2) begin
         n_bad++;
         $display("FAIL parity_good: got %h (%0d beats) expected %h", beat(1), q_data.size(), {8'h03, 1'b1, 1'b0});
      end
   endtask
`endif

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_overrun();
      test_rst_mid_frame();
`ifdef BIDIR_RX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
